scope_capture_ctrl: RTL

Acquisition sequencer for the ice40 scope. It sits between the ADC sample stream and the sample RAM. It decimates by a programmable ratio, fills a circular pre-trigger window, detects a level/slope trigger, and captures the post-trigger window. It then hands the filled buffer to readout with a done/ack handshake.

---
 rtl/scope_pkg.sv | 12 +
 rtl/scope_decimator.sv | 22 ++
 rtl/scope_capture_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// scope_pkg: default widths, RAM depth derivation and sequencer state encoding
package scope_pkg;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DECIM_W = 14;

    typedef enum logic [2:0] {IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE} captureState;

    function automatic int depthOf(input int addrW);
        return 2 ** addrW;
    endfunction
endpackage

// File: rtl/scope_decimator.sv
// scope_decimator: counts valid samples and strobes on every (iRatio+1)-th one
module scope_decimator
    import scope_pkg::*;
#(
    parameter int DECIM_W = DEF_DECIM_W
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iClear,
    input  logic [DECIM_W-1:0] iRatio,
    input  logic               iValid,
    output logic               oStrobe
);
    logic [DECIM_W-1:0] count;

    always_comb oStrobe = iValid && count == iRatio;

    always_ff @(posedge iClk) begin
        if (iRst || iClear) count <= '0;
        else if (iValid) count <= oStrobe ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: decimate, fill pre-trigger ring, detect level/slope trigger, capture post window
// Build option SCOPE_FORCE_TRIG_EN adds iForce_Trig, a sticky request that triggers on the next strobe.
module scope_capture_ctrl
    import scope_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DECIM_W = DEF_DECIM_W
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iArm,
    input  logic [DECIM_W-1:0] iDecim,
    input  logic [DATA_W-1:0]  iTrig_Level,
    input  logic               iTrig_Rising,
    input  logic [ADDR_W-1:0]  iPre_Trig,
    input  logic [DATA_W-1:0]  iData,
    input  logic               iData_Valid,
`ifdef SCOPE_FORCE_TRIG_EN
    input  logic               iForce_Trig,
`endif
    output logic               oWr_En,
    output logic [ADDR_W-1:0]  oWr_Addr,
    output logic [DATA_W-1:0]  oWr_Data,
    output logic [ADDR_W-1:0]  oTrig_Addr,
    output logic               oBusy,
    output logic               oDone,
    input  logic               iDone_Ack
);
    localparam int DEPTH = depthOf(ADDR_W);
    localparam logic [ADDR_W-1:0] MAX_PRE = ADDR_W'(DEPTH - 1);

    captureState        state;
    logic [DECIM_W-1:0] decimReg;
    logic [DATA_W-1:0]  levelReg, prevSample;
    logic [ADDR_W-1:0]  preReg, preLeft, postLeft, ptr, preClamp;
    logic               risingReg, prevValid, strobe, arm, capturing, slopeHit, trigHit;
`ifdef SCOPE_FORCE_TRIG_EN
    logic               forceReq;
`endif

    always_comb begin
        arm       = state == IDLE && iArm;
        capturing = state == PRETRIG || state == WAIT_TRIG || state == POSTTRIG;
        preClamp  = iPre_Trig > MAX_PRE ? MAX_PRE : iPre_Trig;
        // the previous strobed sample may come from the pre-trigger phase
        slopeHit  = prevValid && (risingReg ? prevSample < levelReg && iData >= levelReg
                                            : prevSample > levelReg && iData <= levelReg);
`ifdef SCOPE_FORCE_TRIG_EN
        trigHit   = slopeHit || forceReq;
`else
        trigHit   = slopeHit;
`endif
    end

    scope_decimator #(.DECIM_W(DECIM_W)) decimator (
        .iClk   (iClk),
        .iRst   (iRst),
        .iClear (arm),
        .iRatio (decimReg),
        .iValid (iData_Valid),
        .oStrobe(strobe)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= IDLE;
            decimReg   <= '0;
            levelReg   <= '0;
            risingReg  <= 1'b0;
            preReg     <= '0;
            preLeft    <= '0;
            postLeft   <= '0;
            ptr        <= '0;
            prevSample <= '0;
            prevValid  <= 1'b0;
            oWr_En     <= 1'b0;
            oWr_Addr   <= '0;
            oWr_Data   <= '0;
            oTrig_Addr <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
`ifdef SCOPE_FORCE_TRIG_EN
            forceReq   <= 1'b0;
`endif
        end else begin
            oWr_En <= capturing && strobe;
            if (capturing && strobe) begin
                oWr_Addr   <= ptr;
                oWr_Data   <= iData;
                ptr        <= ptr + 1'b1;
                prevSample <= iData;
                prevValid  <= 1'b1;
            end
`ifdef SCOPE_FORCE_TRIG_EN
            if (state == WAIT_TRIG && iForce_Trig) forceReq <= 1'b1;
`endif
            case (state)
                IDLE: if (iArm) begin
                    decimReg  <= iDecim;
                    levelReg  <= iTrig_Level;
                    risingReg <= iTrig_Rising;
                    preReg    <= preClamp;
                    preLeft   <= preClamp;
                    ptr       <= '0;
                    prevValid <= 1'b0;
                    oBusy     <= 1'b1;
`ifdef SCOPE_FORCE_TRIG_EN
                    forceReq  <= 1'b0;
`endif
                    state     <= preClamp == '0 ? WAIT_TRIG : PRETRIG;
                end
                PRETRIG: if (strobe) begin
                    preLeft <= preLeft - 1'b1;
                    if (preLeft == ADDR_W'(1)) state <= WAIT_TRIG;
                end
                WAIT_TRIG: if (strobe && trigHit) begin
                    oTrig_Addr <= ptr;
                    postLeft   <= MAX_PRE - preReg;
`ifdef SCOPE_FORCE_TRIG_EN
                    forceReq   <= 1'b0;
`endif
                    if (preReg == MAX_PRE) begin
                        state <= DONE;
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                    end else begin
                        state <= POSTTRIG;
                    end
                end
                POSTTRIG: if (strobe) begin
                    postLeft <= postLeft - 1'b1;
                    if (postLeft == ADDR_W'(1)) begin
                        state <= DONE;
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                    end
                end
                DONE: if (iDone_Ack) begin
                    state <= IDLE;
                    oDone <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
